// File: rtl/mem_responder_if.sv
// Request/response bundle between a requester and mem_responder.
// Request fields are held stable by the requester until ready.
interface mem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        ready;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req_valid, req_we,
    output req_addr, req_wdata,
    input  busy, ready, err, rdata
  );

  modport slave (
    input  req_valid, req_we,
    input  req_addr, req_wdata,
    output busy, ready, err, rdata
  );
endinterface

// File: rtl/mem_responder.sv
// Unified word RAM responder with programmable wait states.
// Returns a one-cycle registered ready/err pulse per request.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic           cclk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int unsigned CW =
    (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            we_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            busy_q;
  logic            ready_q;
  logic            err_q;
  logic [31:0]     rdata_q;

  logic [31:0]     mem [DEPTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic                  ok;
  logic                  access;

  assign idx    = addr_q[ADDR_WIDTH+1:2];
  assign ok     = (addr_q[1:0] == 2'b00) &&
                  (addr_q[31:ADDR_WIDTH+2] == '0);
  assign access = (state_q == BUSY) && (cnt_q == '0);

  // RAM is never reset; a reset on the access edge drops the write
  always_ff @(posedge cclk) begin
    if (access && we_q && ok && !rst) begin
      mem[idx] <= wdata_q;
    end
  end

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            cnt_q   <= CW'(WAIT_STATES);
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= DONE;
            ready_q <= 1'b1;
            if (ok) begin
              err_q <= 1'b0;
              if (!we_q) begin
                rdata_q <= mem[idx];
              end
            end else begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule
